// File: rtl/ball_motion_if.sv
// ball_motion_if: strobe, serve and paddle inputs plus ball position and event outputs
interface ball_motion_if;
    logic       clk_ball;
    logic       serve;
    logic [8:0] paddle_l_y;
    logic [8:0] paddle_r_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       hit;
    logic       miss_l;
    logic       miss_r;
    modport master (output clk_ball, serve, paddle_l_y, paddle_r_y,
                    input  ball_x, ball_y, hit, miss_l, miss_r);
    modport slave  (input  clk_ball, serve, paddle_l_y, paddle_r_y,
                    output ball_x, ball_y, hit, miss_l, miss_r);
endinterface

// File: rtl/ball_motion.sv
// ball_motion: steps the PONG ball once per synchronised clk_ball rise with wall/paddle bounces and misses
module ball_motion #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BALL_SIZE  = 8,
    parameter int PADDLE_H   = 64,
    parameter int PADDLE_W   = 8,
    parameter int PADDLE_L_X = 16,
    parameter int PADDLE_R_X = 616,
    parameter int MISS_HOLD  = 32
) (
    input logic          clk,
    input logic          reset,
    ball_motion_if.slave bus
);
    localparam int CW = $clog2(MISS_HOLD) + 1;
    localparam logic [9:0] X_C    = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [8:0] Y_C    = 9'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] X_MAX  = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [8:0] Y_MAX  = 9'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] X_HL   = 10'(PADDLE_L_X + PADDLE_W);
    localparam logic [9:0] X_HR   = 10'(PADDLE_R_X - BALL_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(MISS_HOLD - 1);

    typedef enum logic [1:0] {IDLE, MOVE, MISS} state_t;

    state_t        state, state_n;
    logic          s1, s2, s3, step;
    logic [9:0]    x, x_n;
    logic [8:0]    y, y_n;
    logic          dx, dx_n, dy, dy_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          hit_q, ml_q, mr_q, hit_n, ml_n, mr_n;
    logic [10:0]   y11, pl11, pr11;
    logic          ov_l, ov_r;

    assign step = s2 & ~s3;
    assign y11  = {2'b0, y};
    assign pl11 = {2'b0, bus.paddle_l_y};
    assign pr11 = {2'b0, bus.paddle_r_y};
    assign ov_l = (y11 + 11'(BALL_SIZE) > pl11) && (y11 < pl11 + 11'(PADDLE_H));
    assign ov_r = (y11 + 11'(BALL_SIZE) > pr11) && (y11 < pr11 + 11'(PADDLE_H));

    assign bus.ball_x = x;
    assign bus.ball_y = y;
    assign bus.hit    = hit_q;
    assign bus.miss_l = ml_q;
    assign bus.miss_r = mr_q;

    // synchronise clk_ball and keep the previous level for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.clk_ball;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // state, position, direction, miss counter and event pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            x     <= X_C;
            y     <= Y_C;
            dx    <= 1'b1;
            dy    <= 1'b1;
            cnt   <= '0;
            hit_q <= 1'b0;
            ml_q  <= 1'b0;
            mr_q  <= 1'b0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            dx    <= dx_n;
            dy    <= dy_n;
            cnt   <= cnt_n;
            hit_q <= hit_n;
            ml_q  <= ml_n;
            mr_q  <= mr_n;
        end
    end

    // next state: reflect first, then move by the new direction; a miss freezes x and y
    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        dx_n    = dx;
        dy_n    = dy;
        cnt_n   = cnt;
        hit_n   = 1'b0;
        ml_n    = 1'b0;
        mr_n    = 1'b0;
        case (state)
            IDLE: state_n = bus.serve ? MOVE : IDLE;
            MOVE: if (step) begin
                dy_n = (dy && y == Y_MAX) ? 1'b0 : (!dy && y == 9'd0) ? 1'b1 : dy;
                if (!dx && x == 10'd0) begin
                    ml_n    = 1'b1;
                    dx_n    = 1'b1;
                    state_n = MISS;
                end else if (dx && x == X_MAX) begin
                    mr_n    = 1'b1;
                    dx_n    = 1'b0;
                    state_n = MISS;
                end else begin
                    hit_n = (!dx && x == X_HL && ov_l) || (dx && x == X_HR && ov_r);
                    dx_n  = hit_n ? ~dx : dx;
                    x_n   = dx_n ? x + 10'd1 : x - 10'd1;
                    y_n   = dy_n ? y + 9'd1 : y - 9'd1;
                end
            end
            MISS: if (step) begin
                cnt_n   = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                state_n = (cnt == CNT_LAST) ? IDLE : MISS;
                x_n     = (cnt == CNT_LAST) ? X_C : x;
                y_n     = (cnt == CNT_LAST) ? Y_C : y;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
